// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath: default widths, output-stage FSM
// states and activation saturation limits.
package nn_pkg;

    localparam int NN_ACC_W = 17;
    localparam int NN_OUT_W = 8;

    typedef enum logic [1:0] {
        ACCUM,
        DRAIN,
        EMIT
    } nos_state_t;

    function automatic int sat_umax(input int out_w);
        return (1 << out_w) - 1;
    endfunction

    function automatic int sat_smax(input int out_w);
        return (1 << (out_w - 1)) - 1;
    endfunction

    function automatic int sat_smin(input int out_w);
        return -(1 << (out_w - 1));
    endfunction

    localparam int NN_SAT_UMAX = sat_umax(NN_OUT_W);
    localparam int NN_SAT_SMAX = sat_smax(NN_OUT_W);
    localparam int NN_SAT_SMIN = sat_smin(NN_OUT_W);

endpackage

// File: rtl/requant_sat.sv
// Combinational requantiser: bias add, optional ReLU, right shift and saturation.
// NOS_RELU_EN selects unsigned ReLU output; otherwise the output is signed two's complement.
module requant_sat
    import nn_pkg::*;
#(
    parameter int ACC_W = NN_ACC_W,
    parameter int OUT_W = NN_OUT_W
) (
    input  logic [ACC_W-1:0]     acc,
    input  logic signed [ACC_W:0] bias,
    input  logic [3:0]           shift_amt,
    output logic [OUT_W-1:0]     data,
    output logic                 sat
);

    // Two extra bits: one for the sign, one for the carry of unsigned acc + signed bias.
    localparam int SW = ACC_W + 2;

    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] sh;

    always_comb begin
        sum = $signed({2'b00, acc}) + SW'(bias);
        sh  = sum >>> shift_amt;
    end

`ifdef NOS_RELU_EN
    localparam logic signed [SW-1:0] HI = SW'(sat_umax(OUT_W));

    always_comb begin
        data = '0;
        sat  = 1'b0;
        if (sum[SW-1]) begin
            data = '0;
        end else if (sh > HI) begin
            data = '1;
            sat  = 1'b1;
        end else begin
            data = sh[OUT_W-1:0];
        end
    end
`else
    localparam logic signed [SW-1:0] HI = SW'(sat_smax(OUT_W));
    localparam logic signed [SW-1:0] LO = SW'(sat_smin(OUT_W));

    always_comb begin
        data = '0;
        sat  = 1'b0;
        if (sh > HI) begin
            data = {1'b0, {(OUT_W-1){1'b1}}};
            sat  = 1'b1;
        end else if (sh < LO) begin
            data = {1'b1, {(OUT_W-1){1'b0}}};
            sat  = 1'b1;
        end else begin
            data = sh[OUT_W-1:0];
        end
    end
`endif

endmodule

// File: rtl/neuron_output_stage.sv
// Post-MAC output stage: waits out the MAC pipeline, requantises the sum, hands it off
// over valid/ready and clears the accumulator. Activation mode set by NOS_RELU_EN.
module neuron_output_stage
    import nn_pkg::*;
#(
    parameter int ACC_W       = NN_ACC_W,
    parameter int OUT_W       = NN_OUT_W,
    parameter int MAC_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mac_enable,
    input  logic                 mac_last,
    input  logic [ACC_W-1:0]     acc_in,
    input  logic signed [ACC_W:0] bias,
    input  logic [3:0]           shift_amt,
    output logic                 mac_clear,
    output logic                 stall,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sat
);

    nos_state_t       state;
    logic [3:0]       drain_cnt;
    logic             capture;
    logic [OUT_W-1:0] q_data;
    logic             q_sat;

    requant_sat #(
        .ACC_W(ACC_W),
        .OUT_W(OUT_W)
    ) u_requant (
        .acc      (acc_in),
        .bias     (bias),
        .shift_amt(shift_amt),
        .data     (q_data),
        .sat      (q_sat)
    );

    // Reset gates the clear so an aborted drain never pulses the MAC reset.
    always_comb begin
        capture   = (state == DRAIN) && (drain_cnt == '0);
        mac_clear = capture && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ACCUM;
            drain_cnt <= '0;
            stall     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (mac_enable && mac_last) begin
                        state     <= DRAIN;
                        drain_cnt <= 4'(MAC_LATENCY - 1);
                        stall     <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (capture) begin
                        out_data  <= q_data;
                        out_sat   <= q_sat;
                        out_valid <= 1'b1;
                        state     <= EMIT;
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        stall     <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_output_stage.sv
// Bench for neuron_output_stage: behavioural MAC in front, arithmetic reference model behind.
module tb_neuron_output_stage;

    localparam int ACC_W = 17;
    localparam int OUT_W = 8;
    localparam int LAT   = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 mac_enable;
    logic                 mac_last;
    logic [ACC_W-1:0]     acc_in;
    logic signed [ACC_W:0] bias;
    logic [3:0]           shift_amt;
    logic                 mac_clear;
    logic                 stall;
    logic [OUT_W-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_sat;

    logic [7:0]       mac_a;
    logic [7:0]       mac_b;
    logic [15:0]      mac_p;
    logic             p_valid;
    logic [ACC_W-1:0] acc;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int clear_cnt = 0;
    int clear_edge = 0;
    int op_a[8];
    int op_b[8];

    always #5 clk = ~clk;

    neuron_output_stage #(
        .ACC_W(ACC_W),
        .OUT_W(OUT_W),
        .MAC_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mac_enable(mac_enable),
        .mac_last(mac_last),
        .acc_in(acc_in),
        .bias(bias),
        .shift_amt(shift_amt),
        .mac_clear(mac_clear),
        .stall(stall),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sat(out_sat)
    );

    // Two-stage MAC: product registered, then accumulated; reset by reset | mac_clear.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mac_clear) begin
            clear_cnt  <= clear_cnt + 1;
            clear_edge <= cyc + 1;
        end
        if (reset || mac_clear) begin
            p_valid <= 1'b0;
            mac_p   <= '0;
            acc     <= '0;
        end else begin
            p_valid <= mac_enable;
            mac_p   <= mac_a * mac_b;
            if (p_valid) acc <= acc + ACC_W'(mac_p);
        end
    end
    assign acc_in = acc;

    function automatic void ref_model(input int total, input int bv, input int sh,
                                      output int d, output bit s);
        int v;
        v = total + bv;
        s = 1'b0;
`ifdef NOS_RELU_EN
        if (v < 0) v = 0;
        v = v / (1 << sh);
        if (v > 255) begin
            v = 255;
            s = 1'b1;
        end
`else
        v = v >>> sh;
        if (v > 127) begin
            v = 127;
            s = 1'b1;
        end else if (v < -128) begin
            v = -128;
            s = 1'b1;
        end
`endif
        d = v & 255;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        mac_enable = 1'b0; mac_last = 1'b0; mac_a = '0; mac_b = '0;
        bias = '0; shift_amt = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset out_data: got %0h expected 0", out_data); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
        checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL reset out_sat: got %b expected 0", out_sat); end
        checks++; if (mac_clear !== 1'b0) begin errors++; $display("FAIL reset mac_clear: got %b expected 0", mac_clear); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset stall: got %b expected 0", stall); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid_after: got %b expected 0", out_valid); end
    endtask

    // Issues op_a/op_b[0..n-1] as one neuron, checks timing, result and the hold/accept behaviour.
    task automatic run_neuron(input string name, input int n, input int bv, input int sh,
                              input int hold, input bit pulse);
        int total = 0;
        int t_last = 0;
        int rise = -1;
        int clr0;
        int exp_d;
        bit exp_s;
        int k = 0;
        for (int i = 0; i < n; i++) total += op_a[i] * op_b[i];
        ref_model(total, bv, sh, exp_d, exp_s);
        @(negedge clk);
        bias = 18'(bv);
        shift_amt = 4'(sh);
        out_ready = 1'b0;
        clr0 = clear_cnt;
        for (int i = 0; i < n; i++) begin
            mac_enable = 1'b1;
            mac_last = (i == n - 1);
            mac_a = 8'(op_a[i]);
            mac_b = 8'(op_b[i]);
            @(posedge clk);
            #1;
            if (i == n - 1) t_last = cyc;
            @(negedge clk);
        end
        mac_enable = 1'b0; mac_last = 1'b0; mac_a = '0; mac_b = '0;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL %s stall_drain: got %b expected 1", name, stall); end
        while (k < 20) begin
            if (out_valid === 1'b1) begin
                rise = cyc;
                break;
            end
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (rise < 0) begin
            errors++;
            $display("FAIL %s valid_timeout: got no out_valid expected within 20 cycles", name);
            out_ready = 1'b1;
            repeat (3) @(posedge clk);
            out_ready = 1'b0;
            return;
        end
        checks++; if (rise != t_last + LAT) begin errors++; $display("FAIL %s valid_cycle: got %0d expected %0d", name, rise - t_last, LAT); end
        checks++; if (clear_edge != t_last + LAT) begin errors++; $display("FAIL %s clear_cycle: got %0d expected %0d", name, clear_edge - t_last, LAT); end
        checks++; if (out_data !== 8'(exp_d)) begin errors++; $display("FAIL %s out_data: got %0d expected %0d", name, out_data, exp_d); end
        checks++; if (out_sat !== exp_s) begin errors++; $display("FAIL %s out_sat: got %b expected %b", name, out_sat, exp_s); end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            mac_enable = pulse && (h % 2 == 0);
            mac_last = mac_enable;
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL %s hold_valid_stall: got %b%b expected 11", name, out_valid, stall); end
            checks++; if (out_data !== 8'(exp_d) || out_sat !== exp_s) begin errors++; $display("FAIL %s hold_data: got %0d/%b expected %0d/%b", name, out_data, out_sat, exp_d, exp_s); end
        end
        @(negedge clk);
        mac_enable = 1'b0; mac_last = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s accept_valid: got %b expected 0", name, out_valid); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL %s accept_stall: got %b expected 0", name, stall); end
        checks++; if (clear_cnt - clr0 != 1) begin errors++; $display("FAIL %s clear_count: got %0d expected 1", name, clear_cnt - clr0); end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_products();
        op_a[0] = 2; op_b[0] = 3; op_a[1] = 4; op_b[1] = 5; op_a[2] = 10; op_b[2] = 10;
        run_neuron("prod126", 3, 0, 0, 0, 1'b0);
    endtask

    task automatic test_shift_sat();
        op_a[0] = 10; op_b[0] = 100;
        run_neuron("acc1000_sh2", 1, 0, 2, 0, 1'b0);
        run_neuron("acc1000_sh1", 1, 0, 1, 1, 1'b0);
    endtask

    task automatic test_neg_bias();
        op_a[0] = 2; op_b[0] = 63;
        run_neuron("bias_neg200", 1, -200, 0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        op_a[0] = 3; op_b[0] = 11; op_a[1] = 5; op_b[1] = 6;
        run_neuron("ready_low5", 2, 17, 0, 5, 1'b1);
    endtask

    task automatic test_reset_in_drain();
        int clr0;
        bit seen = 1'b0;
        @(negedge clk);
        bias = '0; shift_amt = '0;
        mac_enable = 1'b1; mac_last = 1'b1; mac_a = 8'd5; mac_b = 8'd5;
        @(posedge clk);
        @(negedge clk);
        mac_enable = 1'b0; mac_last = 1'b0; mac_a = '0; mac_b = '0;
        clr0 = clear_cnt;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL drain_reset valid: got 1 expected 0"); end
        checks++; if (clear_cnt != clr0) begin errors++; $display("FAIL drain_reset clear: got %0d expected 0", clear_cnt - clr0); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL drain_reset stall: got %b expected 0", stall); end
        op_a[0] = 7; op_b[0] = 9;
        run_neuron("after_reset63", 1, 0, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            int n;
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) begin
                op_a[i] = int'($urandom_range(0, 150));
                op_b[i] = int'($urandom_range(0, 150));
            end
            run_neuron("random", n, int'($urandom_range(0, 140000)) - 70000,
                       int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_products();
        test_shift_sat();
        test_neg_bias();
        test_backpressure();
        test_reset_in_drain();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
